// File: rtl/rr_sched_pkg.sv
// Shared definitions for the burst round-robin scheduler.
//   state_t        : scheduler state encoding (IDLE, BURST)
//   MAX_N          : largest supported requester count
//   onehot_to_idx  : binary index of the set bit in a one-hot vector
package rr_sched_pkg;

  localparam int MAX_N = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // The caller zero-extends to MAX_N bits. An all-zero input returns 0.
  function automatic logic [3:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker. It finds the first set request bit,
// scanning upward from ptr and wrapping from N-1 to 0.
// Ports:
//   req     in  N    request vector
//   ptr     in  IDW  highest-priority position
//   any     out 1    at least one request is set
//   pick    out N    one-hot winner (zero when any=0)
//   pick_id out IDW  binary index of the winner
module rr_pick
  import rr_sched_pkg::*;
#(
  parameter int N = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           any,
  output logic [N-1:0]   pick,
  output logic [IDW-1:0] pick_id
);

  logic [N-1:0] rot;
  logic [N-1:0] rot_pick;

  // Rotate so that the ptr position lands at bit 0. This also works when N
  // is not a power of two, because the doubled vector is shifted by at
  // most N-1.
  assign rot      = N'({req, req} >> ptr);
  // Isolate the lowest set bit.
  assign rot_pick = rot & (~rot + N'(1));
  // Rotate back: take the upper half of the doubled vector shifted left.
  assign pick     = N'({rot_pick, rot_pick} << ptr >> N);

  assign any      = |req;
  assign pick_id  = IDW'(onehot_to_idx(MAX_N'(pick)));

endmodule

// File: rtl/burst_rr_scheduler.sv
// Burst round-robin scheduler. It hands one beat-oriented resource to one
// of N requesters for a whole burst of req_len+1 beats. It arbitrates only
// while idle, and always leaves one idle cycle between bursts.
// Ports:
//   clk, rst   clock; synchronous active-high reset
//   req        N         per-requester burst request (level)
//   req_len    N*LEN_W   per-requester burst length minus 1
//   res_ready  1         resource accepts the current beat
//   grant      N         registered one-hot owner (zero when idle)
//   gnt_id     IDW       binary index of the owner (zero when idle)
//   busy       1         burst in progress
//   beat_fire  1         beat transferred this cycle
//   last_beat  1         owner is on its final beat
//   done       1         final beat transferred this cycle
//
// state | meaning
// IDLE  | no owner; arbitrate among requests this cycle
// BURST | grant held; count beats down to zero against res_ready
module burst_rr_scheduler
  import rr_sched_pkg::*;
#(
  parameter int N = 4,
  parameter int LEN_W = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N*LEN_W-1:0] req_len,
  input  logic               res_ready,
  output logic [N-1:0]       grant,
  output logic [IDW-1:0]     gnt_id,
  output logic               busy,
  output logic               beat_fire,
  output logic               last_beat,
  output logic               done
);

  state_t           state_q;
  logic [N-1:0]     grant_q;
  logic [IDW-1:0]   gnt_id_q;
  logic [LEN_W-1:0] cnt_q;
  logic [IDW-1:0]   ptr_q;

  logic             pick_any;
  logic [N-1:0]     pick;
  logic [IDW-1:0]   pick_id;
  logic [LEN_W-1:0] len_sel;
  logic [IDW-1:0]   ptr_next;

  rr_pick #(.N(N)) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .any     (pick_any),
    .pick    (pick),
    .pick_id (pick_id)
  );

  always_comb begin
    len_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (pick[i]) len_sel = req_len[i*LEN_W +: LEN_W];
    end
  end

  // An explicit wrap keeps the pointer in range when N is not a power of two.
  assign ptr_next = (pick_id == IDW'(N-1)) ? '0 : pick_id + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      gnt_id_q <= '0;
      cnt_q    <= '0;
      ptr_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            state_q  <= BURST;
            grant_q  <= pick;
            gnt_id_q <= pick_id;
            cnt_q    <= len_sel;
            ptr_q    <= ptr_next;
          end
        end
        BURST: begin
          if (res_ready) begin
            if (cnt_q == '0) begin
              state_q  <= IDLE;
              grant_q  <= '0;
              gnt_id_q <= '0;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant     = grant_q;
  assign gnt_id    = gnt_id_q;
  assign busy      = (state_q == BURST);
  assign beat_fire = busy & res_ready;
  assign last_beat = busy & (cnt_q == '0);
  assign done      = beat_fire & last_beat;

  a_grant_onehot0: assert property (@(posedge clk) disable iff (rst)
    $onehot0(grant_q));
  a_busy_matches_grant: assert property (@(posedge clk) disable iff (rst)
    busy == (|grant_q));

endmodule

// File: doc/burst_rr_scheduler.md
Name: burst_rr_scheduler

Overview:
- Shares one beat-oriented resource (for example a memory port or bus master) between N requesters.
- Each requester asks for a burst of 1..2^LEN_W beats. A round-robin arbitration decision is made only when the resource is idle.
- The grant is then held for the whole burst. Beats are counted against the resource's ready signal.
- Sits between the requester clients and the shared resource datapath; it sequences ownership and never carries data.

Parameters:
- N, 4, number of requesters (2..16).
- LEN_W, 4, width of burst length field; burst length = req_len+1, range 1..2^LEN_W beats.
- IDW, $clog2(N), width of granted-index output; derived, not overridden.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- req  input  N  per-requester burst request; level, held until granted.
- req_len  input  N*LEN_W  per-requester burst length minus 1; slice i at [i*LEN_W +: LEN_W].
- res_ready  input  1  resource accepts current beat this cycle.
- grant  output  N  one-hot owner of the resource; registered; all-zero when idle.
- gnt_id  output  IDW  binary index of owner; valid while busy; 0 when idle.
- busy  output  1  burst in progress (equals |grant).
- beat_fire  output  1  busy & res_ready; one beat transferred this cycle.
- last_beat  output  1  busy & (remaining count == 0).
- done  output  1  beat_fire & last_beat; single-cycle pulse on the final beat.

Behaviour:
- States: IDLE and BURST, held in an enumerated state register.
- Reset values:
  - state=IDLE, grant=0, gnt_id=0, busy=0.
  - Remaining-beat counter = 0.
  - Priority pointer = 0, so requester 0 has highest priority.
  - All derived outputs are 0.
- IDLE, no req: remain in IDLE; pointer unchanged.
- IDLE, |req=1 at cycle t:
  - Winner = first set req bit scanning from the pointer upward, wrapping N-1 -> 0.
  - At t+1: state=BURST, grant=onehot(winner), gnt_id=winner, counter=req_len[winner] (sampled at t).
  - At t+1: pointer = (winner+1) mod N.
  - Arbitration latency is 1 cycle.
- BURST:
  - Each cycle with res_ready=1, decrement the counter, except on the last beat.
  - res_ready=0 stalls the burst with no change.
- Last beat: when res_ready=1 and counter==0, done pulses. The next cycle is state=IDLE, grant=0.
- Bubble between bursts: there is exactly one IDLE cycle between consecutive bursts. Back-to-back re-arbitration is not performed.
- A burst of length 1 (req_len=0) occupies one BURST cycle if res_ready=1 on that cycle.
- Changes to req and req_len during BURST are ignored. The owner keeps the grant even if it drops req.
- A req withdrawn while IDLE, before being granted, has no effect.
- Fairness: a continuously asserted req is granted within N-1 intervening bursts.
- Counter width is LEN_W. It never underflows, because decrement is blocked at 0.
- Reset asserted mid-burst: the next cycle has all reset values, the burst is abandoned, and done is not pulsed.
- grant is always one-hot or zero; this is checked by an assertion.
- busy == |grant, checked by an assertion.

Decomposition:
- Package rr_sched_pkg: state enum (IDLE, BURST) and a helper function for one-hot to index.
- Sub-module rr_pick (combinational; parameter N):
  - Inputs: req[N] and pointer[IDW].
  - Outputs: any, one-hot pick[N], pick_id[IDW].
  - Implemented as a rotate, fixed-priority select, rotate back.
  - Instantiated once in burst_rr_scheduler.
- Counter, pointer and FSM live in the top module.

Test Plan:
- Reset, then req=4'b0000 for 5 cycles -> grant=0, busy=0, done never asserted.
- req=4'b0100, req_len[2]=3, res_ready=1:
  - grant=4'b0100 and gnt_id=2 one cycle later.
  - busy for exactly 4 cycles, done on the 4th, then grant=0.
- req=4'b1111 held, all req_len=0, res_ready=1 -> grant sequence 0,1,2,3,0, each burst separated by one idle cycle.
- Pointer=1 after granting 0; req=4'b0001 then req=4'b0011 at the next arbitration -> requester 1 wins before 0.
- req_len=2 with res_ready pattern 1,0,0,1,1 -> counter stalls, done asserted on the 5th BURST cycle, beat_fire count = 3.
- rst asserted on the 2nd beat of a 6-beat burst -> next cycle grant=0, busy=0, pointer=0, and no done pulse.
